// File: rtl/gbc_sysram_pkg.sv
// Shared types and default widths for the GBC system-RAM arbiter slice.
package gbc_sysram_pkg;

   localparam int unsigned SYSRAM_ADDR_W    = 15;
   localparam int unsigned SYSRAM_DATA_W    = 8;
   localparam int unsigned SYSRAM_READ_LAT  = 2;
   localparam int unsigned SYSRAM_AGE_LIMIT = 8;
   localparam int unsigned SYSRAM_AGE_W     = 8;

   // Owner of a BRAM access; NONE marks writes and idle slots in the tag pipe.
   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_CPU,
      SRC_DMA,
      SRC_FILL
   } sysram_src_t;

endpackage

// File: rtl/gbc_sysram_arbiter_if.sv
// Request/grant/return bundle between the three requesters, the arbiter and the BRAM port.
interface gbc_sysram_arbiter_if #(
   parameter int unsigned AddrWidth = gbc_sysram_pkg::SYSRAM_ADDR_W
);
   import gbc_sysram_pkg::*;

   logic                     CpuReq;
   logic                     CpuWrite;
   logic [AddrWidth-1:0]     CpuAddr;
   logic [SYSRAM_DATA_W-1:0] CpuWData;
   logic                     CpuGrant;
   logic                     CpuRValid;
   logic                     CpuDelay;

   logic                     DmaReq;
   logic                     DmaWrite;
   logic [AddrWidth-1:0]     DmaAddr;
   logic [SYSRAM_DATA_W-1:0] DmaWData;
   logic                     DmaGrant;
   logic                     DmaRValid;

   logic                     FillReq;
   logic                     FillWrite;
   logic [AddrWidth-1:0]     FillAddr;
   logic [SYSRAM_DATA_W-1:0] FillWData;
   logic                     FillGrant;
   logic                     FillRValid;

   logic [SYSRAM_DATA_W-1:0] RData;

   logic                     RamEn;
   logic                     RamWe;
   logic [AddrWidth-1:0]     RamAddr;
   logic [SYSRAM_DATA_W-1:0] RamWData;
   logic [SYSRAM_DATA_W-1:0] RamRData;

   // Arbiter side
   modport slave (
      input  CpuReq, CpuWrite, CpuAddr, CpuWData,
      input  DmaReq, DmaWrite, DmaAddr, DmaWData,
      input  FillReq, FillWrite, FillAddr, FillWData,
      input  RamRData,
      output CpuGrant, CpuRValid, CpuDelay,
      output DmaGrant, DmaRValid,
      output FillGrant, FillRValid,
      output RData,
      output RamEn, RamWe, RamAddr, RamWData
   );

   // Requesters plus BRAM side
   modport master (
      output CpuReq, CpuWrite, CpuAddr, CpuWData,
      output DmaReq, DmaWrite, DmaAddr, DmaWData,
      output FillReq, FillWrite, FillAddr, FillWData,
      output RamRData,
      input  CpuGrant, CpuRValid, CpuDelay,
      input  DmaGrant, DmaRValid,
      input  FillGrant, FillRValid,
      input  RData,
      input  RamEn, RamWe, RamAddr, RamWData
   );

endinterface

// File: rtl/gbc_sysram_tag_pipe.sv
// Shift register carrying the owner tag of each issued BRAM access until its read data is due.
module gbc_sysram_tag_pipe
   import gbc_sysram_pkg::*;
#(
   parameter int unsigned Depth = SYSRAM_READ_LAT
) (
   input  logic        Clk,
   input  logic        ResetN,
   input  sysram_src_t i_tag,
   output sysram_src_t o_tag,
   output logic        o_cpu_pending
);

   sysram_src_t r_stage [Depth];

   always_ff @(posedge Clk or negedge ResetN) begin : shift_q
      if (!ResetN) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            r_stage[i] <= SRC_NONE;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int unsigned i = 1; i < Depth; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[Depth-1];

   // Any CPU read still travelling through the BRAM latency window
   always_comb begin : cpu_scan
      o_cpu_pending = 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
         if (r_stage[i] == SRC_CPU) begin
            o_cpu_pending = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gbc_sysram_arbiter.sv
// Single-port system-RAM arbiter: CPU > DMA > Fill with age promotion for Fill,
// tagged read return and the CPU stall term for CATC.
module gbc_sysram_arbiter
   import gbc_sysram_pkg::*;
#(
   parameter int unsigned AddrWidth   = SYSRAM_ADDR_W,
   parameter int unsigned ReadLatency = SYSRAM_READ_LAT,
   parameter int unsigned AgeLimit    = SYSRAM_AGE_LIMIT
) (
   input  logic                Clk,
   input  logic                ResetN,
   gbc_sysram_arbiter_if.slave bus
);

   localparam int unsigned DataWidth = SYSRAM_DATA_W;
   localparam int unsigned AgeWidth  = SYSRAM_AGE_W;
   localparam logic [AgeWidth-1:0] AgeLim = AgeWidth'(AgeLimit);
   localparam logic [AgeWidth-1:0] AgeMax = '1;

   sysram_src_t            w_win;
   logic                   w_fill_prio;
   logic                   w_win_we;
   logic [AddrWidth-1:0]   w_win_addr;
   logic [DataWidth-1:0]   w_win_wdata;
   sysram_src_t            w_ret_tag;
   logic                   w_cpu_inflight;

   logic [AgeWidth-1:0]    r_age;
   logic                   r_ram_en;
   logic                   r_ram_we;
   logic [AddrWidth-1:0]   r_ram_addr;
   logic [DataWidth-1:0]   r_ram_wdata;
   sysram_src_t            r_issue_tag;
   logic [DataWidth-1:0]   r_rdata;
   logic                   r_cpu_rvalid;
   logic                   r_dma_rvalid;
   logic                   r_fill_rvalid;

   // Winner selection; Fill jumps DMA once it has waited AgeLimit cycles
   always_comb begin : arbitrate
      w_fill_prio = bus.FillReq && (r_age >= AgeLim);
      w_win       = SRC_NONE;
      w_win_we    = 1'b0;
      w_win_addr  = '0;
      w_win_wdata = '0;
      if (ResetN) begin
         if (bus.CpuReq) begin
            w_win       = SRC_CPU;
            w_win_we    = bus.CpuWrite;
            w_win_addr  = bus.CpuAddr;
            w_win_wdata = bus.CpuWData;
         end else if (bus.DmaReq && !w_fill_prio) begin
            w_win       = SRC_DMA;
            w_win_we    = bus.DmaWrite;
            w_win_addr  = bus.DmaAddr;
            w_win_wdata = bus.DmaWData;
         end else if (bus.FillReq) begin
            w_win       = SRC_FILL;
            w_win_we    = bus.FillWrite;
            w_win_addr  = bus.FillAddr;
            w_win_wdata = bus.FillWData;
         end
      end
   end

   assign bus.CpuGrant  = (w_win == SRC_CPU);
   assign bus.DmaGrant  = (w_win == SRC_DMA);
   assign bus.FillGrant = (w_win == SRC_FILL);

   // Fill starvation counter, saturating
   always_ff @(posedge Clk or negedge ResetN) begin : age_q
      if (!ResetN) begin
         r_age <= '0;
      end else if (!bus.FillReq || (w_win == SRC_FILL)) begin
         r_age <= '0;
      end else if (r_age != AgeMax) begin
         r_age <= r_age + AgeWidth'(1);
      end
   end

   // Registered BRAM command; address and data hold while idle
   always_ff @(posedge Clk or negedge ResetN) begin : issue_q
      if (!ResetN) begin
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_issue_tag <= SRC_NONE;
      end else begin
         r_ram_en    <= (w_win != SRC_NONE);
         r_ram_we    <= w_win_we;
         r_issue_tag <= ((w_win != SRC_NONE) && !w_win_we) ? w_win : SRC_NONE;
         if (w_win != SRC_NONE) begin
            r_ram_addr  <= w_win_addr;
            r_ram_wdata <= w_win_wdata;
         end
      end
   end

   gbc_sysram_tag_pipe #(
      .Depth (ReadLatency)
   ) u_tag_pipe (
      .Clk           (Clk),
      .ResetN        (ResetN),
      .i_tag         (r_issue_tag),
      .o_tag         (w_ret_tag),
      .o_cpu_pending (w_cpu_inflight)
   );

   // Read return: capture BRAM data and steer the valid pulse to the tag owner
   always_ff @(posedge Clk or negedge ResetN) begin : return_q
      if (!ResetN) begin
         r_rdata       <= '0;
         r_cpu_rvalid  <= 1'b0;
         r_dma_rvalid  <= 1'b0;
         r_fill_rvalid <= 1'b0;
      end else begin
         r_cpu_rvalid  <= (w_ret_tag == SRC_CPU);
         r_dma_rvalid  <= (w_ret_tag == SRC_DMA);
         r_fill_rvalid <= (w_ret_tag == SRC_FILL);
         if (w_ret_tag != SRC_NONE) begin
            r_rdata <= bus.RamRData;
         end
      end
   end

   assign bus.RamEn      = r_ram_en;
   assign bus.RamWe      = r_ram_we;
   assign bus.RamAddr    = r_ram_addr;
   assign bus.RamWData   = r_ram_wdata;
   assign bus.RData      = r_rdata;
   assign bus.CpuRValid  = r_cpu_rvalid;
   assign bus.DmaRValid  = r_dma_rvalid;
   assign bus.FillRValid = r_fill_rvalid;

   // Stall while the CPU waits for a grant or for its read data to come back
   assign bus.CpuDelay = ResetN &&
                         ((bus.CpuReq && (w_win != SRC_CPU)) ||
                          (r_issue_tag == SRC_CPU) ||
                          w_cpu_inflight);

endmodule
